// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Byte/half/word load-store engine in front of a word-only data
//            memory. Optional perf counters are enabled by MAU_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int N = 32,
    parameter int R = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    output logic         resp_err,
    output logic [N-1:0] resp_rdata,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
`ifdef MAU_PERF_CNT_EN
    ,
    output logic [31:0]  load_cnt,
    output logic [31:0]  store_cnt,
    output logic [31:0]  err_cnt
`endif
);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_RSP  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata16;

    logic         w_misaligned;
    logic         w_accept;
    logic [4:0]   w_shift;
    logic [N-1:0] w_shifted;
    logic [N-1:0] w_load_ext;
    logic [N-1:0] w_mask;
    logic [N-1:0] w_ins;
    logic [N-1:0] w_merged;

    assign w_accept     = req_valid && (r_state == S_IDLE);
    assign w_misaligned = (req_size == 2'b11)
                       || ((req_size == c_SZ_HALF) && req_addr[0])
                       || ((req_size == c_SZ_WORD) && (req_addr[1:0] != 2'b00));

    // Lane offset in bits: halfwords snap to addr[1], bytes use addr[1:0].
    assign w_shift   = (r_size == c_SZ_HALF) ? {r_lane[1], 4'b0000} : {r_lane, 3'b000};
    assign w_shifted = mem_rdata >> w_shift;

    always_comb begin
        w_load_ext = mem_rdata;
        case (r_size)
            c_SZ_BYTE: w_load_ext = {{(N-8){~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            c_SZ_HALF: w_load_ext = {{(N-16){~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default:   w_load_ext = mem_rdata;
        endcase
    end

    assign w_mask   = ((r_size == c_SZ_HALF) ? {{(N-16){1'b0}}, 16'hFFFF}
                                             : {{(N-8){1'b0}}, 8'hFF}) << w_shift;
    assign w_ins    = ({{(N-16){1'b0}}, r_wdata16} << w_shift) & w_mask;
    assign w_merged = (mem_rdata & ~w_mask) | w_ins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_misaligned)                      w_state_nx = S_ERR;
                    else if (req_we && (req_size == c_SZ_WORD)) w_state_nx = S_WR;
                    else                                   w_state_nx = S_RD;
                end
            end
            S_RD:    w_state_nx = r_we ? S_WR : S_RSP;
            S_WR:    w_state_nx = S_RSP;
            S_RSP:   w_state_nx = S_IDLE;
            S_ERR:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Status outputs decode straight from state so reset clears mem_we at once.
    assign req_ready  = (r_state == S_IDLE);
    assign mem_we     = (r_state == S_WR);
    assign resp_valid = (r_state == S_RSP) || (r_state == S_ERR);
    assign resp_err   = (r_state == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_lane     <= 2'b00;
            r_wdata16  <= 16'h0000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_lane     <= req_addr[1:0];
                        r_wdata16  <= req_wdata[15:0];
                        if (w_misaligned) begin
                            resp_rdata <= '0;
                        end else begin
                            mem_addr <= {req_addr[N-1:R+2], req_addr[R+1:2], 2'b00};
                            if (req_we && (req_size == c_SZ_WORD)) begin
                                mem_wdata <= req_wdata;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (r_we) mem_wdata  <= w_merged;
                    else      resp_rdata <= w_load_ext;
                end
                S_WR:    resp_rdata <= '0;
                default: ;
            endcase
        end
    end

`ifdef MAU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt  <= 32'd0;
            store_cnt <= 32'd0;
            err_cnt   <= 32'd0;
        end else begin
            if ((r_state == S_RSP) && !r_we) load_cnt  <= load_cnt + 32'd1;
            if ((r_state == S_RSP) && r_we)  store_cnt <= store_cnt + 32'd1;
            if (r_state == S_ERR)            err_cnt   <= err_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit with a word RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MAU_PERF_CNT_EN
    logic [31:0] load_cnt, store_cnt, err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_data = 32'h0;
    int          we_cnt = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.N(32), .R(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MAU_PERF_CNT_EN
        , .load_cnt(load_cnt), .store_cnt(store_cnt), .err_cnt(err_cnt)
`endif
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (pre_we)      mem[pre_idx] <= pre_data;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issues one request and reports the response latency in cycles (-1 if none).
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        lat = -1; rd = 32'hx; er = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (resp_valid && lat < 0) begin
                lat = k; rd = resp_rdata; er = resp_err;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_tests++;
        if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/valid/err/we=%b required 1000",
                     {req_ready, resp_valid, resp_err, mem_we});
        end
        n_tests++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required all 0",
                     resp_rdata, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_byte;
        logic [31:0] a [3]   = '{32'h11, 32'h12, 32'h13};
        logic        u [3]   = '{1'b0, 1'b0, 1'b1};
        logic [31:0] exp [3] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080};
        int lat; logic [31:0] rd; logic er;
        preload(6'd4, 32'h80FF7F01);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 2'b00, u[i], a[i], 32'h0, lat, rd, er);
            n_tests++;
            if (rd !== exp[i] || er !== 1'b0) begin
                n_fail++;
                $display("FAIL load_byte[%0d]: rdata=%h err=%b required %h err=0", i, rd, er, exp[i]);
            end
            n_tests++;
            if (lat !== 2) begin
                n_fail++;
                $display("FAIL load_byte_lat[%0d]: latency=%0d required 2", i, lat);
            end
        end
    endtask

    task automatic test_load_half;
        logic [31:0] a [3]   = '{32'h12, 32'h12, 32'h10};
        logic        u [3]   = '{1'b0, 1'b1, 1'b0};
        logic [31:0] exp [3] = '{32'hFFFF80FF, 32'h000080FF, 32'h00007F01};
        int lat; logic [31:0] rd; logic er;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 2'b01, u[i], a[i], 32'h0, lat, rd, er);
            n_tests++;
            if (rd !== exp[i] || er !== 1'b0 || lat !== 2) begin
                n_fail++;
                $display("FAIL load_half[%0d]: rdata=%h err=%b lat=%0d required %h err=0 lat=2",
                         i, rd, er, lat, exp[i]);
            end
        end
    endtask

    task automatic test_store;
        int lat; logic [31:0] rd; logic er; int w0;
        preload(6'd8, 32'h11223344);
        w0 = we_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h123456AB, lat, rd, er);
        n_tests++;
        if (mem[8] !== 32'h1122AB44 || we_cnt - w0 !== 1) begin
            n_fail++;
            $display("FAIL store_byte: mem=%h we_pulses=%0d required 1122ab44 and 1", mem[8], we_cnt - w0);
        end
        n_tests++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL store_byte_rsp: lat=%0d err=%b rdata=%h required 3 0 0", lat, er, rd);
        end
        preload(6'd8, 32'h11223344);
        w0 = we_cnt;
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h9876BEEF, lat, rd, er);
        n_tests++;
        if (mem[8] !== 32'hBEEF3344 || we_cnt - w0 !== 1 || lat !== 3) begin
            n_fail++;
            $display("FAIL store_half: mem=%h we_pulses=%0d lat=%0d required beef3344 1 3",
                     mem[8], we_cnt - w0, lat);
        end
        w0 = we_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h24, 32'hDEADBEEF, lat, rd, er);
        n_tests++;
        if (mem[9] !== 32'hDEADBEEF || we_cnt - w0 !== 1 || lat !== 2 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL store_word: mem=%h we_pulses=%0d lat=%0d err=%b required deadbeef 1 2 0",
                     mem[9], we_cnt - w0, lat, er);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er);
        n_tests++;
        if (rd !== 32'hBEEF3344 || lat !== 2) begin
            n_fail++;
            $display("FAIL load_word: rdata=%h lat=%0d required beef3344 2", rd, lat);
        end
    endtask

    task automatic test_errors;
        logic        we [3]  = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz [3]  = '{2'b10, 2'b01, 2'b11};
        logic [31:0] a [3]   = '{32'h06, 32'h03, 32'h10};
        int lat; logic [31:0] rd; logic er; int w0;
        logic [31:0] m0, m4;
        preload(6'd0, 32'hCAFEF00D);
        m0 = mem[0]; m4 = mem[4];
        for (int i = 0; i < 3; i++) begin
            w0 = we_cnt;
            do_req(we[i], sz[i], 1'b0, a[i], 32'h55AA55AA, lat, rd, er);
            n_tests++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
                n_fail++;
                $display("FAIL err[%0d]: err=%b rdata=%h lat=%0d required 1 0 1", i, er, rd, lat);
            end
            n_tests++;
            if (we_cnt - w0 !== 0 || mem[0] !== m0 || mem[4] !== m4) begin
                n_fail++;
                $display("FAIL err_mem[%0d]: we_pulses=%0d mem0=%h mem4=%h required 0 %h %h",
                         i, we_cnt - w0, mem[0], mem[4], m0, m4);
            end
        end
`ifdef MAU_PERF_CNT_EN
        n_tests++;
        if (load_cnt !== 32'd7 || store_cnt !== 32'd3 || err_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_cnt: load=%0d store=%0d err=%0d required 7 3 3",
                     load_cnt, store_cnt, err_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        #1 req_size = 2'b00; req_addr = 32'h11;
        @(negedge clk);
        n_tests++;
        if ({resp_valid, resp_err, req_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_err: valid/err/ready=%b required 110", {resp_valid, resp_err, req_ready});
        end
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: ready=%b required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'h0000007F) begin
            n_fail++;
            $display("FAIL b2b_load: valid/err=%b rdata=%h required 10 0000007f",
                     {resp_valid, resp_err}, resp_rdata);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        preload(6'd8, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'h000000CD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_wr: mem_we=%b required 1 in write cycle", mem_we);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_we !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: mem_we=%b resp_valid=%b required 0 0", mem_we, resp_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_ready: ready=%b required 1", req_ready);
        end
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0 || mem[8] !== 32'h11223344) begin
            n_fail++;
            $display("FAIL rst_mid_after: resp_seen=%b mem=%h required 0 11223344", seen, mem[8]);
        end
`ifdef MAU_PERF_CNT_EN
        n_tests++;
        if ({load_cnt, store_cnt, err_cnt} !== 96'h0) begin
            n_fail++;
            $display("FAIL rst_mid_cnt: load=%0d store=%0d err=%0d required 0 0 0",
                     load_cnt, store_cnt, err_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store engine that drives the word-addressed data memory on behalf of the datapath.
- Accepts byte, halfword and word loads and stores over a valid/ready request interface.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores, because the data memory only writes whole words.
- Reports misaligned or invalid accesses as errors instead of touching memory.

Parameters:
- n, 32, data/address width in bits
- r, 6, memory index width; mem_addr drives bits [r+1:0] meaningfully, upper bits pass through unchanged

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=invalid
- req_unsigned  in  1  zero-extend load when 1, sign-extend when 0
- req_addr  in  n  byte address
- req_wdata  in  n  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: access rejected
- resp_rdata  out  n  extended load data; 0 for stores and errors
- mem_we  out  1  to data memory write_enable
- mem_addr  out  n  to data memory addr, low 2 bits forced 0
- mem_wdata  out  n  to data memory writedata
- mem_rdata  in  n  from data memory readdata (combinational read)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0. Asserting reset mid-operation drops the pending request, deasserts mem_we immediately and issues no response.
- Handshake: req_ready=1 only in IDLE. A transfer occurs on a rising edge with req_valid&&req_ready. The unit latches we, size, unsigned, addr and wdata. There is no response backpressure; resp_valid is high for exactly one cycle.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]. A halfword uses addr[1] to select bits [15:0] or [31:16].
- Misaligned: size 11; half with addr[0]=1; word with addr[1:0]!=0. Path: IDLE->ERR->IDLE. ERR drives resp_valid=1, resp_err=1, resp_rdata=0. No mem_we.
- Load: IDLE->RD->RSP->IDLE. In RD, mem_addr = latched addr with low 2 bits cleared. mem_rdata is captured at the end of RD and then extracted and extended. In RSP, resp_valid=1 and resp_rdata holds the result. Accept at edge N; resp_valid is high in cycle N+2.
- Word store: IDLE->WR->RSP->IDLE. In WR, mem_we=1 and mem_wdata=req_wdata. resp_valid is high in cycle N+2.
- Sub-word store: IDLE->RD->WR->RSP->IDLE. RD captures the old word. WR writes the old word with only the addressed lane(s) replaced by the low byte/half of wdata. resp_valid is high in cycle N+3.
- mem_we is asserted only in WR, for exactly one cycle per store.
- mem_addr and mem_wdata are registered. They hold their last values in IDLE.
- Back-to-back: a new request can be accepted in the cycle after RSP/ERR, since the unit has returned to IDLE.
- resp_rdata holds its value until the next response.

Optional Feature:
- Macro: MAU_PERF_CNT_EN.
- When defined, three additional output ports are added: load_cnt, store_cnt and err_cnt, each 32 bits.
  - Each counter increments in the RSP/ERR cycle of its access type.
  - Counters wrap from 0xFFFFFFFF to 0.
  - Counters are cleared by rst_n.
- When not defined, these ports and their registers do not exist, and all other behaviour is identical.

Test Plan:
- Preload word 0x80FF7F01 at address 0x10. Load byte, signed, addr 0x11 -> resp_rdata=0x0000007F. Addr 0x12, signed -> 0xFFFFFFFF. Addr 0x13, unsigned -> 0x00000080. Each response arrives 2 cycles after accept.
- Load half, signed, addr 0x12 -> 0xFFFF80FF. Unsigned -> 0x000080FF.
- Start with word 0x11223344 at 0x20. Store byte 0xAB to 0x21 -> memory word becomes 0x1122AB44. Exactly one mem_we pulse. resp_valid at N+3.
- Store half 0xBEEF to 0x22 -> 0xBEEF3344. Store word 0xDEADBEEF to 0x24 -> memory 0xDEADBEEF. Word store resp_valid at N+2.
- Error cases: load word at 0x06, store half at 0x03, and size=11 -> resp_err=1, resp_rdata=0, mem_we never asserted, memory unchanged.
- Reset case: assert rst_n=0 during the WR cycle of a sub-word store -> mem_we drops asynchronously, no resp_valid, req_ready=1 after release. If MAU_PERF_CNT_EN is defined, all counters read 0.
